// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: instruction kinds,
// load funct3 encodings and FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_ALU  = 2'b01,
    WB_LOAD = 2'b10
  } wb_kind_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StCommit
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute, data-memory response and register-file write signals of the writeback stage.
// master: the surrounding core side; slave: the writeback stage.
interface writeback_stage_if;
  logic        EX_VALID;
  logic        EX_READY;
  logic [1:0]  EX_KIND;
  logic [4:0]  EX_RD;
  logic [31:0] EX_RESULT;
  logic [2:0]  EX_FUNCT3;
  logic [1:0]  EX_ADDR_LO;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic [4:0]  A3;
  logic [31:0] WB;
  logic        WE;
  logic        BUSY;
  logic        LOAD_ERR;

  modport master (
    output EX_VALID, EX_KIND, EX_RD, EX_RESULT, EX_FUNCT3, EX_ADDR_LO,
    output MEM_RVALID, MEM_RDATA,
    input  EX_READY, A3, WB, WE, BUSY, LOAD_ERR
  );

  modport slave (
    input  EX_VALID, EX_KIND, EX_RD, EX_RESULT, EX_FUNCT3, EX_ADDR_LO,
    input  MEM_RVALID, MEM_RDATA,
    output EX_READY, A3, WB, WE, BUSY, LOAD_ERR
  );
endinterface

// File: rtl/load_extend.sv
// Combinational RISC-V load lane selection with sign/zero extension.
// Unknown funct3 values pass the full word through.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU results and extended load data to the register file.
// Optional load timeout with sticky LOAD_ERR is enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              CLK,
  input logic              RST,
  writeback_stage_if.slave bus
);

  wb_state_e   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_q, addr_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wb_q, wb_d;
  logic        we_q, we_d;
  logic [31:0] ext_data;
  logic        handshake;
  logic        timeout;

  assign bus.EX_READY = (state_q != StWaitMem);
  assign bus.BUSY     = (state_q == StWaitMem);
  assign bus.A3       = a3_q;
  assign bus.WB       = wb_q;
  assign bus.WE       = we_q;
  assign handshake    = bus.EX_VALID & bus.EX_READY;

  load_extend u_load_extend (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q),
    .rdata_i   (bus.MEM_RDATA),
    .data_o    (ext_data)
  );

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Counter idles at zero outside WAIT_MEM, so it is clear on every entry.
  assign timeout = (state_q == StWaitMem) && !bus.MEM_RVALID &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StWaitMem) cnt_d = cnt_q + 1'b1;
    err_d = err_q | timeout;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.LOAD_ERR = err_q;
`else
  assign timeout      = 1'b0;
  assign bus.LOAD_ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    a3_d    = a3_q;
    wb_d    = wb_q;
    we_d    = 1'b0;

    case (state_q)
      StIdle, StCommit: begin
        state_d = StIdle;
        if (handshake) begin
          case (bus.EX_KIND)
            WB_ALU: begin
              a3_d    = bus.EX_RD;
              wb_d    = bus.EX_RESULT;
              we_d    = |bus.EX_RD;
              state_d = StCommit;
            end
            WB_LOAD: begin
              rd_d    = bus.EX_RD;
              f3_d    = bus.EX_FUNCT3;
              addr_d  = bus.EX_ADDR_LO;
              state_d = StWaitMem;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StWaitMem: begin
        if (bus.MEM_RVALID) begin
          a3_d    = rd_q;
          wb_d    = ext_data;
          we_d    = |rd_q;
          state_d = StCommit;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      rd_q    <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      a3_q    <= '0;
      wb_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      a3_q    <= a3_d;
      wb_q    <= wb_d;
      we_q    <= we_d;
    end
  end

endmodule
